beta_mem_ctrl: RTL

Parametrised, synthesizable memory block for the beta core, replacing the zero-latency combinational instruction/data arrays.
- Two independent ports, each with a req/ack handshake and a programmable wait-state count: an instruction read port and a data read/write port with byte enables.
- Error reporting for misaligned and out-of-range data accesses.
- Sits between core fetch/LSU and the shared word array; used in both simulation and FPGA builds.

---
 rtl/beta_mem_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/beta_mem_ctrl.sv
// beta_mem_ctrl: two-port wait-stated word memory (i: fetch read port, d: byte-enabled load/store port with error flag), rst async active-low
module beta_mem_port #(
    parameter int NWAIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic accept,
    output logic done,
    output logic ack
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    localparam logic [3:0] CNT0 = NWAIT == 0 ? 4'd0 : 4'(NWAIT - 1);
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        accept = 1'b0;
        done = 1'b0;
        ack = state_q == ACK;
        if (state_q == WAIT) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
                state_d = ACK;
                done = 1'b1;
            end
        end else if (req) begin
            accept = 1'b1;
            cnt_d = CNT0;
            state_d = NWAIT == 0 ? ACK : WAIT;
            done = NWAIT == 0;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

module beta_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int I_WAIT = 1,
    parameter int D_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,
    output logic                  d_err
);
    localparam int IW = $clog2(DEPTH);
    localparam int BW = DATA_W / 8;
    logic [DATA_W-1:0] mem [DEPTH];
    logic i_acc, i_done, d_acc, d_done;
    logic [IW-1:0] i_idx_q, i_idx_d, d_idx;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic d_we_q, d_we_d;
    logic [BW-1:0] d_be_q, d_be_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic d_err_q, d_err_d, d_bad, wr_en;
    logic unused_ok;
    beta_mem_port #(.NWAIT(I_WAIT)) u_i (.clk(clk), .rst(rst), .req(i_req), .accept(i_acc), .done(i_done), .ack(i_ack));
    beta_mem_port #(.NWAIT(D_WAIT)) u_d (.clk(clk), .rst(rst), .req(d_req), .accept(d_acc), .done(d_done), .ack(d_ack));
    assign unused_ok = ^{i_addr[1:0], i_addr >> (IW + 2)};
    // with zero wait states the access happens on the accepting edge, so the live inputs are used
    always_comb begin
        i_idx_d = i_acc ? i_addr[IW+1:2] : i_idx_q;
        d_addr_d = d_acc ? d_addr : d_addr_q;
        d_we_d = d_acc ? d_we : d_we_q;
        d_be_d = d_acc ? d_be : d_be_q;
        d_wdata_d = d_acc ? d_wdata : d_wdata_q;
        d_idx = d_addr_d[IW+1:2];
        d_bad = |d_addr_d[1:0] || |(d_addr_d >> (IW + 2));
        i_rdata_d = i_done ? mem[i_idx_d] : i_rdata_q;
        d_rdata_d = d_done ? ((d_bad || d_we_d) ? '0 : mem[d_idx]) : d_rdata_q;
        d_err_d = d_done && d_bad;
        wr_en = d_done && d_we_d && !d_bad && rst;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_idx_q <= '0;
            d_addr_q <= '0;
            d_we_q <= 1'b0;
            d_be_q <= '0;
            d_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            d_err_q <= 1'b0;
        end else begin
            i_idx_q <= i_idx_d;
            d_addr_q <= d_addr_d;
            d_we_q <= d_we_d;
            d_be_q <= d_be_d;
            d_wdata_q <= d_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            d_err_q <= d_err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int k = 0; k < BW; k++)
                if (d_be_d[k]) mem[d_idx][8*k +: 8] <= d_wdata_d[8*k +: 8];
    end
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign d_err = d_err_q;
endmodule
